// File: rtl/servant_uart_loader.sv
// UART boot loader: receives a length-prefixed 8N1 image and writes it to RAM
// as 32-bit Wishbone writes, holding the CPU in reset until the load is done.
module servant_uart_loader #(
    parameter int CLK_DIV = 139,
    parameter int memsize = 8192
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic        i_rx,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_err
);
    localparam int            CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV / 2 - 1);
    localparam logic [31:0]   MEM_BYTES = 32'(memsize);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_HDR, LD_DATA, LD_DONE} ld_state_t;

    logic          rx_meta_q, rx_sync_q;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr;

    ld_state_t     ld_state_q, ld_state_d;
    logic [1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   byte_idx_q, byte_idx_d;
    logic [31:0]   asm_dat_q, asm_dat_d;
    logic [3:0]    asm_sel_q, asm_sel_d;
    logic          final_q, final_d;
    logic [31:0]   wb_adr_q, wb_adr_d;
    logic [31:0]   wb_dat_q, wb_dat_d;
    logic [3:0]    wb_sel_q, wb_sel_d;
    logic          cyc_q, cyc_d;
    logic          err_q, err_d;

    logic [1:0]    lane;
    logic          last_byte;
    logic [31:0]   len_n;
    logic [31:0]   asm_dat_n;
    logic [3:0]    asm_sel_n;

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            rx_valid_q <= 1'b0;
            ld_state_q <= LD_HDR;
            hdr_cnt_q  <= '0;
            len_q      <= '0;
            byte_idx_q <= '0;
            asm_dat_q  <= '0;
            asm_sel_q  <= '0;
            final_q    <= 1'b0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
            wb_sel_q   <= '0;
            cyc_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            rx_valid_q <= rx_valid_d;
            ld_state_q <= ld_state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            asm_dat_q  <= asm_dat_d;
            asm_sel_q  <= asm_sel_d;
            final_q    <= final_d;
            wb_adr_q   <= wb_adr_d;
            wb_dat_q   <= wb_dat_d;
            wb_sel_q   <= wb_sel_d;
            cyc_q      <= cyc_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        rx_valid_d = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = CNT_HALF;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    cnt_d      = CNT_FULL;
                    bit_d      = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    rx_valid_d = rx_sync_q;
                    rx_ferr    = !rx_sync_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        ld_state_d = ld_state_q;
        hdr_cnt_d  = hdr_cnt_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        asm_dat_d  = asm_dat_q;
        asm_sel_d  = asm_sel_q;
        final_d    = final_q;
        wb_adr_d   = wb_adr_q;
        wb_dat_d   = wb_dat_q;
        wb_sel_d   = wb_sel_q;
        cyc_d      = cyc_q;
        err_d      = err_q;

        lane      = byte_idx_q[1:0];
        last_byte = (byte_idx_q + 32'd1) == len_q;
        len_n     = {shift_q, len_q[31:8]};
        asm_dat_n = asm_dat_q | (32'(shift_q) << {lane, 3'b000});
        asm_sel_n = asm_sel_q | (4'b0001 << lane);

        if (cyc_q && i_wb_ack) cyc_d = 1'b0;
        if (rx_ferr && ld_state_q != LD_DONE) err_d = 1'b1;

        unique case (ld_state_q)
            LD_HDR: begin
                if (rx_valid_q) begin
                    len_d     = len_n;
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    if (hdr_cnt_q == 2'd3) begin
                        byte_idx_d = '0;
                        ld_state_d = (len_n == '0) ? LD_DONE : LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (rx_valid_q && !final_q) begin
                    byte_idx_d = byte_idx_q + 32'd1;
                    if (last_byte) final_d = 1'b1;
                    if (byte_idx_q >= MEM_BYTES) begin
                        err_d = 1'b1;
                    end else if (lane == 2'd3 || last_byte) begin
                        asm_dat_d = '0;
                        asm_sel_d = '0;
                        // Previous write still pending: the word cannot be held, so drop it.
                        if (cyc_q) begin
                            err_d = 1'b1;
                        end else begin
                            wb_adr_d = {byte_idx_q[31:2], 2'b00};
                            wb_dat_d = asm_dat_n;
                            wb_sel_d = asm_sel_n;
                            cyc_d    = 1'b1;
                        end
                    end else begin
                        asm_dat_d = asm_dat_n;
                        asm_sel_d = asm_sel_n;
                    end
                end
                if (final_q && (!cyc_q || i_wb_ack)) ld_state_d = LD_DONE;
            end
            default: ;
        endcase
    end

    assign o_wb_adr  = wb_adr_q;
    assign o_wb_dat  = wb_dat_q;
    assign o_wb_sel  = wb_sel_q;
    assign o_wb_cyc  = cyc_q;
    assign o_wb_we   = cyc_q;
    assign o_err     = err_q;
    assign o_done    = (ld_state_q == LD_DONE);
    assign o_cpu_rst = (ld_state_q != LD_DONE);

endmodule

// File: tb/tb_servant_uart_loader.sv
// Bench for servant_uart_loader: serial image in, Wishbone writes checked
// against a word-packing model, plus done/err/reset behaviour.
module tb_servant_uart_loader;
    localparam int CLK_DIV = 8;
    localparam int MEMSIZE = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_ack;
    logic        cpu_rst;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    servant_uart_loader #(.CLK_DIV(CLK_DIV), .memsize(MEMSIZE)) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_rx     (rx),
        .o_wb_adr (wb_adr),
        .o_wb_dat (wb_dat),
        .o_wb_sel (wb_sel),
        .o_wb_we  (wb_we),
        .o_wb_cyc (wb_cyc),
        .i_wb_ack (wb_ack),
        .o_cpu_rst(cpu_rst),
        .o_done   (done),
        .o_err    (err)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   ack_delay = 0;
    int   unstable = 0;
    int   dropped = 0;
    int   last_ack_cyc = -1;
    int   done_cyc = -1;
    int   last_start_cyc = 0;
    bit   done_seen = 0;
    wr_t  got_q[$];
    logic [7:0] data_a [0:127];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // RAM side: record each write, hold ack off for ack_delay cycles, watch stability
    initial begin
        wr_t w;
        wb_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (wb_cyc) begin
                w.adr = wb_adr;
                w.dat = wb_dat;
                w.sel = wb_sel;
                got_q.push_back(w);
                if (wb_we !== 1'b1) unstable++;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge clk);
                    if (!wb_cyc) begin
                        dropped++;
                        break;
                    end
                    if (wb_adr !== w.adr || wb_dat !== w.dat || wb_sel !== w.sel || wb_we !== 1'b1)
                        unstable++;
                end
                if (wb_cyc) begin
                    wb_ack = 1'b1;
                    last_ack_cyc = cyc_n;
                    @(negedge clk);
                    wb_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done && !done_seen) begin
                done_seen = 1'b1;
                done_cyc  = cyc_n;
            end
        end
    end

    task automatic clear_tb();
        got_q.delete();
        unstable     = 0;
        dropped      = 0;
        done_seen    = 1'b0;
        done_cyc     = -1;
        last_ack_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_we", 32'(wb_we), 32'd0);
        chk("rst_adr", wb_adr, 32'd0);
        chk("rst_dat", wb_dat, 32'd0);
        chk("rst_sel", 32'(wb_sel), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        clear_tb();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        last_start_cyc = cyc_n;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = stop;
        repeat (CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
    endtask

    task automatic send_header(input logic [31:0] len, input int ferr_after);
        logic [31:0] hdr;
        hdr = len;
        for (int i = 0; i < 4; i++) begin
            send_byte(hdr[8*i +: 8], 1'b1);
            if (i == ferr_after) send_byte(8'($urandom), 1'b0);
        end
    endtask

    // Sends header + LEN data bytes, then checks the writes against a word-packing model
    task automatic do_load(input logic [31:0] len, input int ferr_after, input int delay,
                           input bit preset);
        wr_t  e;
        wr_t  exp_q[$];
        logic exp_err;
        int   n;
        ack_delay = delay;
        n = int'(len);
        if (!preset)
            for (int i = 0; i < n; i++) data_a[i] = 8'($urandom);
        send_header(len, ferr_after);
        for (int i = 0; i < n; i++) send_byte(data_a[i], 1'b1);
        for (int k = 0; k < 400 && !done; k++) @(negedge clk);
        repeat (2) @(negedge clk);

        for (int w = 0; 4 * w < n && 4 * w < MEMSIZE; w++) begin
            e.adr = 32'(4 * w);
            e.dat = '0;
            e.sel = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * w + l < n) begin
                    e.dat[8*l +: 8] = data_a[4*w+l];
                    e.sel[l]        = 1'b1;
                end
            end
            exp_q.push_back(e);
        end
        exp_err = (n > MEMSIZE) || (ferr_after >= 0);

        chk("done", 32'(done), 32'd1);
        chk("cpu_rst", 32'(cpu_rst), 32'd0);
        chk("err", 32'(exp_err), 32'(err));
        chk("nwrites", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("adr[%0d]", i), got_q[i].adr, exp_q[i].adr);
            chk($sformatf("dat[%0d]", i), got_q[i].dat, exp_q[i].dat);
            chk($sformatf("sel[%0d]", i), 32'(got_q[i].sel), 32'(exp_q[i].sel));
        end
        chk("stable", 32'(unstable), 32'd0);
        chk("cyc_dropped", 32'(dropped), 32'd0);
        if (n > 0 && n <= MEMSIZE)
            chk("done_after_ack", 32'(done_cyc - last_ack_cyc), 32'd1);
        if (n == 0)
            chk("len0_done_lat",
                32'((done_cyc - last_start_cyc) >= 78 && (done_cyc - last_start_cyc) <= 82),
                32'd1);
    endtask

    initial begin
        logic [7:0] d1 [0:7];
        logic [7:0] d2 [0:4];
        rst = 1'b1;
        rx  = 1'b1;
        d1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        d2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};

        do_reset();
        for (int i = 0; i < 8; i++) data_a[i] = d1[i];
        do_load(32'd8, -1, 2, 1'b1);

        do_reset();
        for (int i = 0; i < 5; i++) data_a[i] = d2[i];
        do_load(32'd5, -1, 3, 1'b1);

        do_reset();
        do_load(32'd0, -1, 0, 1'b0);

        do_reset();
        do_load(32'd3, 0, 1, 1'b0);

        do_reset();
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("glitch_err", 32'(err), 32'd0);
        chk("glitch_cyc", 32'(wb_cyc), 32'd0);
        do_load(32'd6, -1, 20, 1'b0);

        do_reset();
        do_load(32'd68, -1, int'($urandom_range(0, 4)), 1'b0);

        for (int r = 0; r < 4; r++) begin
            do_reset();
            do_load(32'($urandom_range(1, 24)), -1, int'($urandom_range(0, 20)), 1'b0);
        end

        // Reset while a write is outstanding mid-image, then a fresh load without another reset
        do_reset();
        ack_delay = 60;
        send_header(32'd16, -1);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
        repeat (4) @(negedge clk);
        chk("mid_cyc_before", 32'(wb_cyc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_cyc_after", 32'(wb_cyc), 32'd0);
        chk("mid_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clear_tb();
        do_load(32'd2, -1, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/servant_uart_loader.md
Name: servant_uart_loader

Overview:
- UART boot loader; sits upstream of the servant RAM arbiter port.
- Receives a length-prefixed program image over an 8N1 serial line and writes it into RAM as 32-bit Wishbone writes.
- Holds the CPU in reset until the image has been written, then releases it.
- Replaces the memfile preload on boards without RAM initialisation.

Parameters:
- CLK_DIV, 139, clock cycles per UART bit (16 MHz / 115200); minimum 4.
- memsize, 8192, RAM size in bytes; power of two.

Ports:
- i_wb_clk  in  1  system clock.
- i_wb_rst  in  1  reset; synchronous to i_wb_clk, active-high.
- i_rx  in  1  asynchronous UART receive line; idle high.
- o_wb_adr  out  32  byte address of the write; word aligned, [1:0]=0.
- o_wb_dat  out  32  write data, little-endian byte packing.
- o_wb_sel  out  4  byte enables.
- o_wb_we  out  1  write enable; equal to o_wb_cyc.
- o_wb_cyc  out  1  cycle request; held until ack.
- i_wb_ack  in  1  single-cycle ack from RAM.
- o_cpu_rst  out  1  CPU reset request; high until load completes.
- o_done  out  1  load complete; sticky.
- o_err  out  1  framing or overflow error seen; sticky.

Behaviour:
- Reset values: o_wb_cyc=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_cpu_rst=1, o_done=0, o_err=0. RX and loader FSMs return to IDLE/HDR; all counters clear.
- Reset mid-operation aborts any transfer immediately. An outstanding cycle is dropped; the next load starts from header byte 0.
- i_rx passes through a 2-flop synchroniser, initialised to 1 on reset. All RX timing below is measured on the synchronised signal.
- RX FSM:
  - IDLE: on synced rx=0 -> START, bit counter loaded with CLK_DIV/2-1.
  - START: at count expiry, rx=0 -> DATA; rx=1 -> IDLE (glitch, no byte, no error).
  - DATA: sample every CLK_DIV cycles, 8 bits, LSB first -> STOP.
  - STOP: sample after CLK_DIV cycles.
    - rx=1: byte valid for exactly one cycle.
    - rx=0: byte discarded, o_err set.
    - Either way, return to IDLE.
- Loader FSM:
  - HDR: first 4 valid bytes form LEN[31:0], little-endian. After the 4th byte: LEN=0 -> DONE, else -> DATA.
  - DATA: each byte is placed in lane (byte_idx[1:0]) of the assembly register, and byte_idx increments.
    - Lane 3 filled, or last byte (byte_idx+1==LEN): the word moves to the write register. The write uses o_wb_adr = {byte_idx[31:2],2'b00} and sel = lanes filled. A partial last word has unfilled lanes sel=0 and data 0.
    - Assembly clears after the hand-off.
  - Write handshake:
    - o_wb_cyc/o_wb_we asserted the cycle after the hand-off, with adr/dat/sel stable.
    - Deassert in the cycle after i_wb_ack=1.
    - i_wb_ack while cyc=0 is ignored.
    - The assembly and write registers are separate, so new bytes are accepted while a write is outstanding.
    - A new word handed off while cyc=1 is a protocol violation: the word is dropped and o_err set. RAM ack latency must stay below 9*CLK_DIV.
  - Overflow: bytes with byte_idx >= memsize are counted but not written, and o_err is set.
  - After the last byte's write is acked (or the last byte was dropped for overflow) -> DONE.
  - DONE: o_done=1 and o_cpu_rst=0 from the cycle after the final ack. Further rx bytes are ignored. Held until i_wb_rst.
- byte_idx is 32-bit, so LEN up to 2^32-1 is accepted. There is no wrap: overflow rule applies.
- Framing-errored bytes do not count toward the header or LEN.

Test Plan (CLK_DIV=8, memsize=64):
- Send 08 00 00 00 11 22 33 44 55 66 77 88 -> two writes: adr 0x0 dat 0x44332211 sel F, then adr 0x4 dat 0x88776655 sel F; o_cpu_rst falls and o_done rises one cycle after 2nd ack; o_err=0.
- Header LEN=5, data AA BB CC DD EE -> second write adr 0x4 dat 0x000000EE sel 0001.
- Header LEN=0 -> no Wishbone cycle; o_done=1 one cycle after 4th header byte's stop bit.
- Byte with stop bit 0 after header byte 1 -> byte discarded, o_err=1; the next 4 good bytes still form LEN and the load completes.
- 3-cycle low glitch on rx while idle -> no byte, o_err=0. Ack delayed 20 cycles -> cyc held, adr/dat stable throughout.
- LEN=68 with memsize=64 -> 16 writes (adr 0x0..0x3C), last 4 bytes dropped, o_err=1, o_done=1. Separately, i_wb_rst asserted mid-DATA -> cyc=0 and o_cpu_rst=1 next cycle, and a fresh header is accepted afterwards.
